// File: rtl/segre_mem_arbiter.sv
// Main-memory port arbiter serialising D$ writebacks/fills and I$ fills, one transaction at a time.
// Optional build macro SEGRE_MEM_ARB_RR_EN: round-robin between caches on simultaneous misses.
module segre_mem_arbiter #(
    parameter int ADDR_SIZE = 32,
    parameter int LANE_SIZE = 128,
    parameter int BYTE_SIZE = 4
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 dc_miss_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    input  logic                 dc_writeback_i,
    input  logic [ADDR_SIZE-1:0] dc_wb_addr_i,
    input  logic [LANE_SIZE-1:0] dc_wb_data_i,
    output logic [LANE_SIZE-1:0] dc_lane_o,
    output logic                 dc_rdy_o,
    input  logic                 ic_miss_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic [LANE_SIZE-1:0] ic_lane_o,
    output logic                 ic_rdy_o,
    output logic                 mm_req_o,
    output logic                 mm_we_o,
    output logic [ADDR_SIZE-1:0] mm_addr_o,
    output logic [LANE_SIZE-1:0] mm_wr_data_o,
    input  logic [LANE_SIZE-1:0] mm_rd_data_i,
    input  logic                 mm_ack_i,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_DC_WB   = 3'd1,
        ARB_DC_FILL = 3'd2,
        ARB_IC_FILL = 3'd3,
        ARB_DC_RESP = 3'd4,
        ARB_IC_RESP = 3'd5
    } arb_state_e;

    arb_state_e state_r, next_state_s;
    logic grant_dc_s;

    logic [ADDR_SIZE-1:0] dc_addr_r, dc_wb_addr_r, ic_addr_r;
    logic [LANE_SIZE-1:0] dc_wb_data_r;
    logic [ADDR_SIZE-1:0] dc_addr_nx_s, dc_wb_addr_nx_s, ic_addr_nx_s;
    logic [LANE_SIZE-1:0] dc_wb_data_nx_s;

    logic [LANE_SIZE-1:0] dc_lane_r, ic_lane_r;
    logic                 mm_req_r, mm_we_r, dc_rdy_r, ic_rdy_r, busy_r;
    logic [ADDR_SIZE-1:0] mm_addr_r;
    logic [LANE_SIZE-1:0] mm_wr_data_r;
    logic                 mm_req_s, mm_we_s, dc_rdy_s, ic_rdy_s, busy_s;
    logic [ADDR_SIZE-1:0] mm_addr_s;
    logic [LANE_SIZE-1:0] mm_wr_data_s;

    function automatic logic [ADDR_SIZE-1:0] lane_align(input logic [ADDR_SIZE-1:0] addr);
        logic [ADDR_SIZE-1:0] res;
        res = addr;
        res[BYTE_SIZE-1:0] = {BYTE_SIZE{1'b0}};
        return res;
    endfunction

`ifdef SEGRE_MEM_ARB_RR_EN
    // Set when the instruction cache received the most recent grant.
    logic last_ic_r;
    assign grant_dc_s = dc_miss_i & (~ic_miss_i | last_ic_r);

    // Last-grant tracking for round-robin.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            last_ic_r <= 1'b1;
        end else if (state_r == ARB_IDLE && grant_dc_s) begin
            last_ic_r <= 1'b0;
        end else if (state_r == ARB_IDLE && ic_miss_i) begin
            last_ic_r <= 1'b1;
        end else begin
            last_ic_r <= last_ic_r;
        end
    end
`else
    assign grant_dc_s = dc_miss_i;
`endif

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (grant_dc_s) begin
                    next_state_s = dc_writeback_i ? ARB_DC_WB : ARB_DC_FILL;
                end else if (ic_miss_i) begin
                    next_state_s = ARB_IC_FILL;
                end else begin
                    next_state_s = ARB_IDLE;
                end
            end
            ARB_DC_WB:   next_state_s = mm_ack_i ? ARB_DC_FILL : ARB_DC_WB;
            ARB_DC_FILL: next_state_s = mm_ack_i ? ARB_DC_RESP : ARB_DC_FILL;
            ARB_IC_FILL: next_state_s = mm_ack_i ? ARB_IC_RESP : ARB_IC_FILL;
            ARB_DC_RESP: next_state_s = ARB_IDLE;
            ARB_IC_RESP: next_state_s = ARB_IDLE;
            default:     next_state_s = ARB_IDLE;
        endcase
    end

    // Request capture: requester inputs are only sampled on the granting edge.
    always_comb begin
        dc_addr_nx_s    = dc_addr_r;
        dc_wb_addr_nx_s = dc_wb_addr_r;
        dc_wb_data_nx_s = dc_wb_data_r;
        ic_addr_nx_s    = ic_addr_r;
        if (state_r == ARB_IDLE && grant_dc_s) begin
            dc_addr_nx_s    = dc_addr_i;
            dc_wb_addr_nx_s = dc_wb_addr_i;
            dc_wb_data_nx_s = dc_wb_data_i;
        end else if (state_r == ARB_IDLE && ic_miss_i) begin
            ic_addr_nx_s = ic_addr_i;
        end else begin
            ic_addr_nx_s = ic_addr_r;
        end
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        mm_req_s     = 1'b0;
        mm_we_s      = 1'b0;
        mm_addr_s    = {ADDR_SIZE{1'b0}};
        mm_wr_data_s = {LANE_SIZE{1'b0}};
        dc_rdy_s     = 1'b0;
        ic_rdy_s     = 1'b0;
        busy_s       = 1'b1;
        case (next_state_s)
            ARB_DC_WB: begin
                mm_req_s     = 1'b1;
                mm_we_s      = 1'b1;
                mm_addr_s    = lane_align(dc_wb_addr_nx_s);
                mm_wr_data_s = dc_wb_data_nx_s;
            end
            ARB_DC_FILL: begin
                mm_req_s  = 1'b1;
                mm_addr_s = lane_align(dc_addr_nx_s);
            end
            ARB_IC_FILL: begin
                mm_req_s  = 1'b1;
                mm_addr_s = lane_align(ic_addr_nx_s);
            end
            ARB_DC_RESP: dc_rdy_s = 1'b1;
            ARB_IC_RESP: ic_rdy_s = 1'b1;
            default:     busy_s   = 1'b0;
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_r      <= ARB_IDLE;
            dc_addr_r    <= {ADDR_SIZE{1'b0}};
            dc_wb_addr_r <= {ADDR_SIZE{1'b0}};
            dc_wb_data_r <= {LANE_SIZE{1'b0}};
            ic_addr_r    <= {ADDR_SIZE{1'b0}};
            dc_lane_r    <= {LANE_SIZE{1'b0}};
            ic_lane_r    <= {LANE_SIZE{1'b0}};
            mm_req_r     <= 1'b0;
            mm_we_r      <= 1'b0;
            mm_addr_r    <= {ADDR_SIZE{1'b0}};
            mm_wr_data_r <= {LANE_SIZE{1'b0}};
            dc_rdy_r     <= 1'b0;
            ic_rdy_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            dc_addr_r    <= dc_addr_nx_s;
            dc_wb_addr_r <= dc_wb_addr_nx_s;
            dc_wb_data_r <= dc_wb_data_nx_s;
            ic_addr_r    <= ic_addr_nx_s;
            if (state_r == ARB_DC_FILL && mm_ack_i) begin
                dc_lane_r <= mm_rd_data_i;
            end else begin
                dc_lane_r <= dc_lane_r;
            end
            if (state_r == ARB_IC_FILL && mm_ack_i) begin
                ic_lane_r <= mm_rd_data_i;
            end else begin
                ic_lane_r <= ic_lane_r;
            end
            mm_req_r     <= mm_req_s;
            mm_we_r      <= mm_we_s;
            mm_addr_r    <= mm_addr_s;
            mm_wr_data_r <= mm_wr_data_s;
            dc_rdy_r     <= dc_rdy_s;
            ic_rdy_r     <= ic_rdy_s;
            busy_r       <= busy_s;
        end
    end

    assign dc_lane_o    = dc_lane_r;
    assign dc_rdy_o     = dc_rdy_r;
    assign ic_lane_o    = ic_lane_r;
    assign ic_rdy_o     = ic_rdy_r;
    assign mm_req_o     = mm_req_r;
    assign mm_we_o      = mm_we_r;
    assign mm_addr_o    = mm_addr_r;
    assign mm_wr_data_o = mm_wr_data_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Randomised bench for segre_mem_arbiter against a queue-of-memory-operations reference model.
module tb_segre_mem_arbiter;

    logic         clk = 1'b0;
    logic         rsn_i;
    logic         dc_miss_i, dc_writeback_i, ic_miss_i, mm_ack_i;
    logic [31:0]  dc_addr_i, dc_wb_addr_i, ic_addr_i;
    logic [127:0] dc_wb_data_i, mm_rd_data_i;
    logic [127:0] dc_lane_o, ic_lane_o, mm_wr_data_o;
    logic         dc_rdy_o, ic_rdy_o, mm_req_o, mm_we_o, busy_o;
    logic [31:0]  mm_addr_o;

    segre_mem_arbiter dut (
        .clk_i(clk), .rsn_i(rsn_i),
        .dc_miss_i(dc_miss_i), .dc_addr_i(dc_addr_i), .dc_writeback_i(dc_writeback_i),
        .dc_wb_addr_i(dc_wb_addr_i), .dc_wb_data_i(dc_wb_data_i),
        .dc_lane_o(dc_lane_o), .dc_rdy_o(dc_rdy_o),
        .ic_miss_i(ic_miss_i), .ic_addr_i(ic_addr_i), .ic_lane_o(ic_lane_o), .ic_rdy_o(ic_rdy_o),
        .mm_req_o(mm_req_o), .mm_we_o(mm_we_o), .mm_addr_o(mm_addr_o),
        .mm_wr_data_o(mm_wr_data_o), .mm_rd_data_i(mm_rd_data_i), .mm_ack_i(mm_ack_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding memory operations of the granted miss, in issue order.
    typedef struct {
        logic         we;
        logic         ic;
        logic [31:0]  addr;
        logic [127:0] data;
    } op_t;

    op_t          q[$];
    logic         m_rdy_dc, m_rdy_ic, m_last_ic;
    logic [127:0] m_dc_lane, m_ic_lane;
    int           order[$];

    function automatic logic m_req_f();
        return q.size() > 0;
    endfunction

    function automatic logic m_busy_f();
        return (q.size() > 0) || m_rdy_dc || m_rdy_ic;
    endfunction

    task automatic model_reset();
        q.delete();
        m_rdy_dc  = 1'b0;
        m_rdy_ic  = 1'b0;
        m_last_ic = 1'b1;
        m_dc_lane = 128'd0;
        m_ic_lane = 128'd0;
    endtask

    task automatic model_step();
        op_t op;
        logic dc_first;
        if (!rsn_i) begin
            model_reset();
        end else if (m_rdy_dc || m_rdy_ic) begin
            m_rdy_dc = 1'b0;
            m_rdy_ic = 1'b0;
        end else if (q.size() > 0) begin
            if (mm_ack_i) begin
                op = q.pop_front();
                if (!op.we && op.ic) begin
                    m_rdy_ic  = 1'b1;
                    m_ic_lane = mm_rd_data_i;
                end else if (!op.we) begin
                    m_rdy_dc  = 1'b1;
                    m_dc_lane = mm_rd_data_i;
                end
            end
        end else begin
`ifdef SEGRE_MEM_ARB_RR_EN
            dc_first = dc_miss_i && (!ic_miss_i || m_last_ic);
`else
            dc_first = dc_miss_i;
`endif
            if (dc_first) begin
                if (dc_writeback_i) q.push_back('{1'b1, 1'b0, dc_wb_addr_i, dc_wb_data_i});
                q.push_back('{1'b0, 1'b0, dc_addr_i, 128'd0});
                m_last_ic = 1'b0;
            end else if (ic_miss_i) begin
                q.push_back('{1'b0, 1'b1, ic_addr_i, 128'd0});
                m_last_ic = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic compare();
        logic         e_we;
        logic [127:0] e_wd;
        e_we = m_req_f() ? q[0].we : 1'b0;
        e_wd = (m_req_f() && q[0].we) ? q[0].data : 128'd0;
        chk("mm_req", mm_req_o, m_req_f());
        chk("mm_we", mm_we_o, e_we);
        chk("mm_wr_data", mm_wr_data_o, e_wd);
        if (m_req_f()) chk("mm_addr", mm_addr_o, q[0].addr & 32'hFFFF_FFF0);
        chk("dc_rdy", dc_rdy_o, m_rdy_dc);
        chk("ic_rdy", ic_rdy_o, m_rdy_ic);
        chk("busy", busy_o, m_busy_f());
        chk("dc_lane", dc_lane_o, m_dc_lane);
        chk("ic_lane", ic_lane_o, m_ic_lane);
    endtask

    // Requesters drop their miss right after seeing their ready pulse.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        if (m_rdy_dc) begin
            dc_miss_i      = 1'b0;
            dc_writeback_i = 1'b0;
        end
        if (m_rdy_ic) ic_miss_i = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((dc_miss_i || ic_miss_i || m_busy_f()) && n < max_cycles) begin
            mm_ack_i     = m_req_f() && ($urandom_range(0, 2) == 0);
            mm_rd_data_i = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (m_rdy_dc) order.push_back(0);
            if (m_rdy_ic) order.push_back(1);
            n++;
        end
        mm_ack_i = 1'b0;
        chk("drain_bound", (n < max_cycles) ? 1'b1 : 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rsn_i = 1'b0;
        step();
        step();
        rsn_i = 1'b1;
    endtask

    initial begin
        rsn_i = 1'b0;
        dc_miss_i = 1'b0; dc_writeback_i = 1'b0; ic_miss_i = 1'b0; mm_ack_i = 1'b0;
        dc_addr_i = 32'd0; dc_wb_addr_i = 32'd0; ic_addr_i = 32'd0;
        dc_wb_data_i = 128'd0; mm_rd_data_i = 128'd0;
        model_reset();
        do_reset();
        chk("rst_req", mm_req_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_lane", dc_lane_o, 128'd0);

        // Instruction-cache fill
        ic_miss_i = 1'b1; ic_addr_i = 32'h0000_1234;
        step();
        chk("ic_addr_lit", mm_addr_o, 32'h0000_1230);
        chk("ic_model_addr", q[0].addr & 32'hFFFF_FFF0, 32'h0000_1230);
        chk("ic_we_lit", mm_we_o, 1'b0);
        mm_ack_i = 1'b1; mm_rd_data_i = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        step();
        mm_ack_i = 1'b0;
        chk("ic_rdy_lit", ic_rdy_o, 1'b1);
        chk("ic_lane_lit", ic_lane_o, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
        chk("ic_dc_rdy_lit", dc_rdy_o, 1'b0);
        step();
        chk("ic_rdy_pulse", ic_rdy_o, 1'b0);

        // Dirty writeback then fill
        dc_miss_i = 1'b1; dc_writeback_i = 1'b1;
        dc_wb_addr_i = 32'h2000_0048; dc_addr_i = 32'h0000_0084;
        dc_wb_data_i = 128'hD1D1_0000_1111_2222_3333_4444_5555_D1D1;
        step();
        chk("wb_we_lit", mm_we_o, 1'b1);
        chk("wb_addr_lit", mm_addr_o, 32'h2000_0040);
        chk("wb_data_lit", mm_wr_data_o, 128'hD1D1_0000_1111_2222_3333_4444_5555_D1D1);
        mm_ack_i = 1'b1;
        step();
        mm_ack_i = 1'b0;
        chk("fill_req_lit", mm_req_o, 1'b1);
        chk("fill_we_lit", mm_we_o, 1'b0);
        chk("fill_addr_lit", mm_addr_o, 32'h0000_0080);
        mm_ack_i = 1'b1; mm_rd_data_i = 128'hD2D2_9999_8888_7777_6666_5555_4444_D2D2;
        step();
        mm_ack_i = 1'b0;
        chk("dc_rdy_lit", dc_rdy_o, 1'b1);
        chk("dc_lane_lit", dc_lane_o, 128'hD2D2_9999_8888_7777_6666_5555_4444_D2D2);
        step();
        step();

        // Two rounds of simultaneous misses from a fresh reset
        do_reset();
        order.delete();
        for (int r = 0; r < 2; r++) begin
            dc_miss_i = 1'b1; dc_addr_i = 32'h0000_0500 + r;
            ic_miss_i = 1'b1; ic_addr_i = 32'h0000_0A00 + r;
            drain(100);
        end
        chk("order_n", order.size(), 4);
        if (order.size() == 4) begin
            chk("order0", order[0], 0);
            chk("order1", order[1], 1);
            chk("order2", order[2], 0);
            chk("order3", order[3], 1);
        end

        // Delayed ack while the requester address moves
        dc_miss_i = 1'b1; dc_addr_i = 32'h0000_4440;
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) dc_addr_i = 32'h0000_9990;
            step();
            chk("hold_addr", mm_addr_o, 32'h0000_4440);
            chk("hold_req", mm_req_o, 1'b1);
        end
        drain(100);

        // Asynchronous reset in the middle of a fill
        dc_miss_i = 1'b1; dc_addr_i = 32'h0000_7770;
        step();
        step();
        rsn_i = 1'b0;
        #1;
        chk("arst_req", mm_req_o, 1'b0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_addr", mm_addr_o, 32'd0);
        chk("arst_lane", dc_lane_o, 128'd0);
        dc_miss_i = 1'b0;
        step();
        rsn_i = 1'b1;
        ic_miss_i = 1'b1; ic_addr_i = 32'h0000_3338;
        step();
        chk("post_rst_addr", mm_addr_o, 32'h0000_3330);
        drain(100);

        // Stray ack while idle
        mm_ack_i = 1'b1;
        step();
        mm_ack_i = 1'b0;
        chk("idle_ack_busy", busy_o, 1'b0);
        chk("idle_ack_rdy", {dc_rdy_o, ic_rdy_o}, 2'b00);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            dc_addr_i      = $urandom;
            dc_wb_addr_i   = $urandom;
            ic_addr_i      = $urandom;
            dc_wb_data_i   = {$urandom, $urandom, $urandom, $urandom};
            mm_rd_data_i   = {$urandom, $urandom, $urandom, $urandom};
            dc_writeback_i = dc_miss_i ? dc_writeback_i : ($urandom_range(0, 1) == 1);
            if (!dc_miss_i && $urandom_range(0, 3) == 0) dc_miss_i = 1'b1;
            if (!ic_miss_i && $urandom_range(0, 3) == 0) ic_miss_i = 1'b1;
            mm_ack_i = ($urandom_range(0, 9) == 0) ? 1'b1 : (m_req_f() && $urandom_range(0, 2) == 0);
            step();
        end
        mm_ack_i = 1'b0;
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/segre_mem_arbiter.md
Name: segre_mem_arbiter

Overview:
Arbitrates the single main-memory port between the data-cache and instruction-cache miss paths. Serialises data-cache dirty-lane writebacks, data-cache line fills and instruction-cache line fills into one memory transaction at a time. Returns each filled lane to its requester with a one-cycle ready pulse. Sits between the cache tag/data controllers and the main-memory model, in the MMU-controller position of the core.

Parameters:
ADDR_SIZE, 32, address width in bits
LANE_SIZE, 128, cache lane width in bits (16 bytes)
BYTE_SIZE, 4, number of lane byte-offset bits; these are cleared on every memory address

Ports:
clk_i  in  1  clock
rsn_i  in  1  asynchronous active-low reset
dc_miss_i  in  1  data-cache fill request; level, held until dc_rdy_o
dc_addr_i  in  ADDR_SIZE  data-cache fill address
dc_writeback_i  in  1  victim lane is dirty; write it back before the fill
dc_wb_addr_i  in  ADDR_SIZE  victim lane address
dc_wb_data_i  in  LANE_SIZE  victim lane data
dc_lane_o  out  LANE_SIZE  data-cache fill data
dc_rdy_o  out  1  data-cache fill-complete pulse
ic_miss_i  in  1  instruction-cache fill request; level, held until ic_rdy_o
ic_addr_i  in  ADDR_SIZE  instruction-cache fill address
ic_lane_o  out  LANE_SIZE  instruction-cache fill data
ic_rdy_o  out  1  instruction-cache fill-complete pulse
mm_req_o  out  1  memory request valid
mm_we_o  out  1  memory request is a write
mm_addr_o  out  ADDR_SIZE  lane-aligned memory address
mm_wr_data_o  out  LANE_SIZE  memory write data
mm_rd_data_i  in  LANE_SIZE  memory read data; valid with mm_ack_i
mm_ack_i  in  1  memory completes the current request
busy_o  out  1  arbiter not in ARB_IDLE

Behaviour:
- Reset: every output is 0, all internal registers are 0, state is ARB_IDLE. Reset is asynchronous and takes effect immediately, including mid-transaction; the memory side must tolerate a dropped request.
- States: ARB_IDLE, ARB_DC_WB, ARB_DC_FILL, ARB_IC_FILL, ARB_DC_RESP, ARB_IC_RESP.
- ARB_IDLE grant:
  - dc_miss_i with dc_writeback_i -> ARB_DC_WB.
  - dc_miss_i alone -> ARB_DC_FILL.
  - otherwise ic_miss_i -> ARB_IC_FILL.
  - Fixed priority: data cache wins.
- Capture on grant: dc_addr_i, dc_wb_addr_i, dc_wb_data_i (or ic_addr_i) are registered. Later changes on requester inputs are ignored until the next grant.
- Request states (ARB_DC_WB, ARB_DC_FILL, ARB_IC_FILL):
  - mm_req_o=1; mm_addr_o = captured address with bits [BYTE_SIZE-1:0] forced to 0.
  - mm_we_o=1 and mm_wr_data_o = captured victim data only in ARB_DC_WB; otherwise mm_we_o=0 and mm_wr_data_o=0.
  - Request fields stay stable until mm_ack_i. There is no timeout.
- On mm_ack_i:
  - ARB_DC_WB -> ARB_DC_FILL; mm_req_o is re-asserted the next cycle with no gap.
  - ARB_DC_FILL -> ARB_DC_RESP; mm_rd_data_i is registered into dc_lane_o.
  - ARB_IC_FILL -> ARB_IC_RESP; mm_rd_data_i is registered into ic_lane_o.
- RESP states: the matching rdy_o is high for exactly one cycle, mm_req_o=0, then -> ARB_IDLE. The requester drops its miss on the edge after rdy_o, so ARB_IDLE sees the updated level. Back-to-back transactions are separated by at least one idle cycle.
- Lane outputs hold their last fill value until the next fill for that cache; they are not cleared by rdy_o.
- mm_ack_i outside request states is ignored: no state change, no rdy_o.
- Fill latency: 1 cycle to grant, plus memory latency, plus 1 RESP cycle. A writeback adds its own memory latency.
- busy_o = (state != ARB_IDLE).

Optional Feature:
SEGRE_MEM_ARB_RR_EN:
- Defined: a last-grant flop (reset value: instruction cache) selects the winner when dc_miss_i and ic_miss_i are both high in ARB_IDLE; the cache not served last wins. A single requester is granted immediately regardless of the flop.
- Undefined: fixed data-cache priority; the instruction cache can starve. No last-grant flop exists.

Test Plan:
- ic_miss_i, ic_addr_i=0x0000_1234 -> mm_req_o=1, mm_addr_o=0x0000_1230, mm_we_o=0; ack with data 0x0123..CDEF -> ic_rdy_o one-cycle pulse next cycle, ic_lane_o=0x0123..CDEF, dc_rdy_o stays 0.
- dc_miss_i + dc_writeback_i, wb_addr=0x2000_0048, wb_data=D1, addr=0x0000_0084 -> write to 0x2000_0040 carrying D1, ack, then read at 0x0000_0080, ack with D2 -> dc_rdy_o pulse, dc_lane_o=D2.
- dc_miss_i and ic_miss_i asserted the same cycle, both held until served:
  - Without the macro -> data-cache fill first, ic_rdy_o follows afterwards.
  - With SEGRE_MEM_ARB_RR_EN, two consecutive rounds of simultaneous misses -> grant order dc, ic, dc, ic.
- mm_ack_i delayed 10 cycles while dc_addr_i changes to 0x0000_9990 mid-wait -> mm_addr_o and mm_req_o unchanged for all 10 cycles.
- rsn_i low during ARB_DC_FILL -> all outputs 0 in the same cycle, busy_o=0; after release, an ic miss is served normally.
- mm_ack_i pulsed in ARB_IDLE -> no rdy_o, state stays ARB_IDLE.
